led_frame_sched: RTL and testbench
==================================

Name: led_frame_sched

Overview:
- Frame scheduler for the LED chain driven behind the I2C LED slave.
- Owns a LED_CNT x 24-bit colour framebuffer that the I2C register side writes.
- On a commit request it walks the buffer in order, handing one 24-bit word per LED to the WS2812-style bit serializer over a valid/ready handshake.
- After the last word it enforces the chain latch gap before the next frame may start.

Parameters:
- LED_CNT, 12, number of LEDs in the chain (2..15).
- IDX_W, 4, width of the LED index; must satisfy 2^IDX_W >= LED_CNT.
- LATCH_CYCLES, 2500, clk cycles of low-line latch gap after the last word; must be >= 1.
- LATCH_W, 12, latch counter width; must satisfy 2^LATCH_W > LATCH_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  framebuffer write strobe from the I2C register side.
- wr_idx  input  IDX_W  LED index for the write.
- wr_data  input  24  GRB colour word for the write.
- commit  input  1  single-cycle pulse requesting a frame refresh (I2C STOP after a write).
- ser_valid  output  1  ser_data holds a word for the serializer.
- ser_data  output  24  colour word to the serializer, MSB shifted first.
- ser_ready  input  1  serializer accepts the word this cycle.
- busy  output  1  high in any state other than IDLE.
- frame_done  output  1  single-cycle pulse when the latch gap completes.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE, idx=0, pending=0, latch counter=0.
  - ser_valid=0, ser_data=0, busy=0, frame_done=0.
  - All framebuffer entries are cleared to 0.
- Writes:
  - With wr_en=1 and wr_idx<LED_CNT, fb[wr_idx] is updated at the clock edge, in any state.
  - wr_idx>=LED_CNT is ignored.
  - A write to an index not yet fetched in the current frame is sent in that frame. A write to an already-fetched index takes effect in the next frame.
- States: IDLE, LOAD, SEND, LATCH.
- IDLE:
  - If commit=1 or pending=1: go to LOAD, set idx=0, clear pending.
  - Latency: commit at edge N puts LOAD at N+1 and ser_valid=1 at N+2.
- LOAD:
  - Register ser_data=fb[idx], set ser_valid=1, go to SEND.
  - If wr_en targets the same idx in this cycle, the old value is fetched (read-before-write).
- SEND:
  - Hold ser_valid and ser_data stable until ser_ready=1.
  - On ser_valid&&ser_ready with idx==LED_CNT-1: set ser_valid=0, load the latch counter with LATCH_CYCLES-1, go to LATCH.
  - On ser_valid&&ser_ready otherwise: set ser_valid=0, increment idx, go to LOAD. This gives one bubble cycle per word.
- LATCH:
  - Decrement the counter each cycle.
  - At counter==0: pulse frame_done for one cycle and go to IDLE.
  - Gap length: exactly LATCH_CYCLES cycles in LATCH.
- Commit while busy:
  - Sets pending=1 and does not restart the current frame.
  - Any number of commits during a frame collapse to one follow-up frame.
  - A commit in the same cycle the state returns to IDLE is not lost: it is captured as pending.
- ser_ready while ser_valid=0 is ignored.
- busy is combinational from state: IDLE→0, else 1.
- Reset mid-frame: everything returns to reset values immediately. The partial frame and pending are discarded; the serializer is expected to be reset by the same rst_n.

Optional Feature:
- Macro: LED_SHADOW_BUF_EN.
- When defined:
  - Writes go to a separate shadow buffer, never to the active buffer.
  - The shadow is copied to the active buffer in one cycle when a frame start is taken out of IDLE, i.e. on the IDLE→LOAD transition.
  - Frames are therefore tear-free: writes during a frame never affect it.
  - Both buffers clear on reset.
  - A same-cycle write and copy includes the write in the copied data.
- When undefined: a single buffer with the direct-write semantics above.

Test Plan:
- Basic frame:
  - Stimulus: write fb[i]=24'h010000*i+i for i=0..11, commit, ser_ready tied 1.
  - Response: 12 words in index order; ser_valid high 1 of every 2 cycles; LATCH lasts 2500 cycles; frame_done pulses once; busy then drops.
- Backpressure:
  - Stimulus: ser_ready low for 7 cycles on word 3.
  - Response: ser_data stays stable at fb[3] with ser_valid=1 throughout; no word is skipped or duplicated.
- Commit collapse:
  - Stimulus: 3 commit pulses during SEND, 1 during LATCH.
  - Response: exactly one extra frame starts right after frame_done; two frame_done pulses in total.
- Out-of-range write:
  - Stimulus: wr_idx=12 and 15 with data 24'hFFFFFF.
  - Response: buffer unchanged; the next frame shows prior values.
- Mid-frame write:
  - Default build, stimulus: write fb[0]=24'hAAAAAA and fb[11]=24'h555555 while idx=5.
  - Default build, response: the current frame sends old fb[0] and new 24'h555555 at idx 11.
  - LED_SHADOW_BUF_EN build: both writes appear only in the next frame.
- Reset mid-frame:
  - Stimulus: assert rst_n low during SEND at idx=6.
  - Response: ser_valid, busy and frame_done are 0 immediately; after release, a commit starts a frame at idx 0 with all words 0.

Source files
------------

// File: rtl/led_frame_sched.sv
// Frame scheduler: owns the LED colour framebuffer and streams one 24-bit word per LED
// to the bit serializer, then holds the chain latch gap. Optional macro: LED_SHADOW_BUF_EN.
module led_frame_sched #(
  parameter int LED_CNT      = 12,
  parameter int IDX_W        = 4,
  parameter int LATCH_CYCLES = 2500,
  parameter int LATCH_W      = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [23:0]      wr_data,
  input  logic             commit,
  output logic             ser_valid,
  output logic [23:0]      ser_data,
  input  logic             ser_ready,
  output logic             busy,
  output logic             frame_done
);

  // Handshake: a word moves to the serializer on any cycle where ser_valid && ser_ready;
  // once raised, ser_valid and ser_data hold stable until that cycle.

  typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_t;

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(LED_CNT - 1);
  localparam logic [LATCH_W-1:0] LATCH_INIT = LATCH_W'(LATCH_CYCLES - 1);

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic               pending, pending_nx;
  logic [LATCH_W-1:0] latch_cnt, latch_nx;
  logic               valid_nx;
  logic [23:0]        data_nx;
  logic [23:0]        fb [LED_CNT];
  logic               wr_hit;
  logic               start;

  assign wr_hit     = wr_en && (wr_idx <= LAST_IDX);
  assign start      = (state == IDLE) && (commit || pending);
  assign busy       = (state != IDLE);
  assign frame_done = (state == LATCH) && (latch_cnt == '0);

`ifdef LED_SHADOW_BUF_EN
  // Writes land in the shadow; the active buffer is refreshed only when a frame starts,
  // folding in a write that arrives on that same edge.
  logic [23:0] shadow [LED_CNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LED_CNT; i++) shadow[i] <= '0;
    end else if (wr_hit) begin
      shadow[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LED_CNT; i++) fb[i] <= '0;
    end else if (start) begin
      for (int i = 0; i < LED_CNT; i++)
        fb[i] <= (wr_hit && (wr_idx == IDX_W'(i))) ? wr_data : shadow[i];
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LED_CNT; i++) fb[i] <= '0;
    end else if (wr_hit) begin
      fb[wr_idx] <= wr_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      pending   <= 1'b0;
      latch_cnt <= '0;
      ser_valid <= 1'b0;
      ser_data  <= '0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      pending   <= pending_nx;
      latch_cnt <= latch_nx;
      ser_valid <= valid_nx;
      ser_data  <= data_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    pending_nx = pending;
    latch_nx   = latch_cnt;
    valid_nx   = ser_valid;
    data_nx    = ser_data;
    // Commits during a frame collapse into a single follow-up request.
    if (state != IDLE && commit) pending_nx = 1'b1;
    case (state)
      IDLE: begin
        if (commit || pending) begin
          state_nx   = LOAD;
          idx_nx     = '0;
          pending_nx = 1'b0;
        end
      end
      LOAD: begin
        data_nx  = fb[idx];
        valid_nx = 1'b1;
        state_nx = SEND;
      end
      SEND: begin
        if (ser_valid && ser_ready) begin
          valid_nx = 1'b0;
          if (idx == LAST_IDX) begin
            latch_nx = LATCH_INIT;
            state_nx = LATCH;
          end else begin
            idx_nx   = idx + 1'b1;
            state_nx = LOAD;
          end
        end
      end
      LATCH: begin
        if (latch_cnt == '0) state_nx = IDLE;
        else                 latch_nx = latch_cnt - 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_led_frame_sched.sv
// Directed bench for led_frame_sched: scoreboard of expected serializer words,
// checked on every accepted handshake, plus timing/latency checks.
module tb_led_frame_sched;
  localparam int LED_CNT      = 12;
  localparam int IDX_W        = 4;
  localparam int LATCH_CYCLES = 2500;
  localparam int LATCH_W      = 12;

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [23:0]      wr_data;
  logic             commit;
  logic             ser_valid;
  logic [23:0]      ser_data;
  logic             ser_ready;
  logic             busy;
  logic             frame_done;

  led_frame_sched #(
    .LED_CNT(LED_CNT), .IDX_W(IDX_W), .LATCH_CYCLES(LATCH_CYCLES), .LATCH_W(LATCH_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .commit(commit), .ser_valid(ser_valid), .ser_data(ser_data), .ser_ready(ser_ready),
    .busy(busy), .frame_done(frame_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] exp_q[$];
  logic [23:0] model [LED_CNT];
  logic [23:0] exp_d;
  int n_cmp = 0, n_err = 0;
  int hs_cnt = 0, done_cnt = 0, busy_cyc = 0, valid_cyc = 0;
  int cyc = 0, last_hs_cyc = 0, done_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (busy) busy_cyc++;
      if (ser_valid) valid_cyc++;
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (ser_valid && ser_ready) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL sb_underflow observed=%0h expected=none", ser_data);
        end else begin
          exp_d = exp_q.pop_front();
          chk("ser_data", 32'(ser_data), 32'(exp_d));
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int i, input logic [23:0] d);
    wr_en   = 1'b1;
    wr_idx  = IDX_W'(i);
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic push_frame();
    for (int i = 0; i < LED_CNT; i++) exp_q.push_back(model[i]);
  endtask

  task automatic wait_hs(input int target, input string tag);
    int n = 0;
    while (hs_cnt < target && n < 3000) begin
      step();
      n++;
    end
    chk(tag, 32'(hs_cnt >= target), 32'd1);
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 6000) begin
      step();
      n++;
    end
    chk(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int base_busy, base_valid, d0, hs_base, n;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0; commit = 1'b0; ser_ready = 1'b0;
    for (int i = 0; i < LED_CNT; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ser_valid), 32'd0);
    chk("rst_data", 32'(ser_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // basic frame
    for (int i = 0; i < LED_CNT; i++) begin
      model[i] = 24'(i * 32'h010000 + i);
      do_write(i, model[i]);
    end
    push_frame();
    base_busy = busy_cyc; base_valid = valid_cyc; d0 = done_cnt;
    ser_ready = 1'b1;
    do_commit();
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_valid", 32'(ser_valid), 32'd0);
    step();
    chk("first_valid", 32'(ser_valid), 32'd1);
    chk("first_word", 32'(ser_data), 32'(model[0]));
    wait_done(d0 + 1, "basic_done_timeout");
    chk("basic_busy_drop", 32'(busy), 32'd0);
    chk("basic_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("basic_busy_cycles", 32'(busy_cyc - base_busy), 32'(2 * LED_CNT + LATCH_CYCLES));
    chk("basic_valid_cycles", 32'(valid_cyc - base_valid), 32'(LED_CNT));
    chk("basic_latch_len", 32'(done_cyc - last_hs_cyc), 32'(LATCH_CYCLES));
    chk("basic_q_empty", 32'(exp_q.size()), 32'd0);

    // out-of-range writes ignored, then backpressure on word 3
    do_write(12, 24'hFFFFFF);
    do_write(15, 24'hFFFFFF);
    model[3] = 24'h123456;
    do_write(3, model[3]);
    push_frame();
    hs_base = hs_cnt; d0 = done_cnt;
    do_commit();
    wait_hs(hs_base + 3, "bp_hs_timeout");
    ser_ready = 1'b0;
    step();
    for (int i = 0; i < 7; i++) begin
      chk("bp_valid_hold", 32'(ser_valid), 32'd1);
      chk("bp_data_hold", 32'(ser_data), 32'(model[3]));
      step();
    end
    ser_ready = 1'b1;
    wait_done(d0 + 1, "bp_done_timeout");
    chk("bp_word_count", 32'(hs_cnt - hs_base), 32'(LED_CNT));
    chk("bp_q_empty", 32'(exp_q.size()), 32'd0);

    // commit collapse: 3 commits in SEND, 1 in LATCH -> one extra frame
    push_frame();
    push_frame();
    hs_base = hs_cnt; d0 = done_cnt;
    do_commit();
    wait_hs(hs_base + 2, "cc_hs_timeout");
    step();
    do_commit();
    repeat (2) begin
      step();
      do_commit();
    end
    wait_hs(hs_base + LED_CNT, "cc_last_timeout");
    repeat (100) step();
    do_commit();
    wait_done(d0 + 1, "cc_done1_timeout");
    chk("cc_idle_gap", 32'(busy), 32'd0);
    step();
    chk("cc_restart_busy", 32'(busy), 32'd1);
    chk("cc_restart_valid", 32'(ser_valid), 32'd0);
    step();
    chk("cc_restart_word", 32'(ser_valid), 32'd1);
    wait_done(d0 + 2, "cc_done2_timeout");
    repeat (30) step();
    chk("cc_done_total", 32'(done_cnt - d0), 32'd2);
    chk("cc_final_idle", 32'(busy), 32'd0);
    chk("cc_q_empty", 32'(exp_q.size()), 32'd0);

    // mid-frame writes at idx 5, follow-up commit on the frame_done cycle
`ifdef LED_SHADOW_BUF_EN
    push_frame();
`else
    for (int i = 0; i < LED_CNT - 1; i++) exp_q.push_back(model[i]);
    exp_q.push_back(24'h555555);
`endif
    hs_base = hs_cnt; d0 = done_cnt;
    do_commit();
    wait_hs(hs_base + 5, "mf_hs_timeout");
    do_write(0, 24'hAAAAAA);
    do_write(11, 24'h555555);
    model[0] = 24'hAAAAAA;
    model[11] = 24'h555555;
    push_frame();
    n = 0;
    while (!frame_done && n < 3000) begin
      step();
      n++;
    end
    chk("mf_done_seen", 32'(frame_done), 32'd1);
    do_commit();
    wait_done(d0 + 2, "mf_done_timeout");
    chk("mf_idle", 32'(busy), 32'd0);
    chk("mf_q_empty", 32'(exp_q.size()), 32'd0);

    // reset mid-frame during SEND at idx 6
    push_frame();
    hs_base = hs_cnt;
    do_commit();
    wait_hs(hs_base + 6, "rst_hs_timeout");
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(ser_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(frame_done), 32'd0);
    chk("midrst_data", 32'(ser_data), 32'd0);
    exp_q.delete();
    for (int i = 0; i < LED_CNT; i++) model[i] = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("postrst_idle", 32'(busy), 32'd0);
    push_frame();
    d0 = done_cnt;
    do_commit();
    wait_done(d0 + 1, "postrst_done_timeout");
    chk("postrst_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
